prog_sequencer: RTL
===================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- D, 12, program counter width.
- LW, 5, jump-target LUT index width; the LUT has 2^LW entries.
- END_ADDR, 128, program counter value that ends a run.
- CW, 16, cycle counter width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high.
- req, in, 1, start request; level-sensitive.
- stall, in, 1, holds the PC and branch evaluation for the current cycle.
- halt, in, 1, decoded halt instruction at the current prog_ctr.
- abs_en, in, 1, absolute-branch instruction at the current prog_ctr.
- rel_en, in, 1, relative-branch instruction at the current prog_ctr.
- cond, in, 1, registered branch condition (zero flag).
- lut_idx, in, LW, LUT index used by an absolute branch.
- rel_off, in, 8, signed two's-complement relative offset.
- lut_we, in, 1, LUT write enable.
- lut_waddr, in, LW, LUT write index.
- lut_wdata, in, D, LUT write data.
- prog_ctr, out, D, current fetch address.
- running, out, 1, high while in the RUN state.
- done, out, 1, registered completion flag.
- cycle_cnt, out, CW, cycles spent in RUN during the last or current run.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-004 In IDLE with req=1, the FSM SHALL enter RUN on the next edge, clear prog_ctr to 0 and clear cycle_cnt to 0.
REQ-005 In RUN, a stalled cycle (stall=1) SHALL leave prog_ctr and the state unchanged and SHALL ignore halt, abs_en and rel_en.
REQ-006 In RUN, when stall=0 and halt=1, the FSM SHALL enter DONE and prog_ctr SHALL hold.
REQ-007 In RUN, when stall=0, halt=0 and prog_ctr==END_ADDR, the FSM SHALL enter DONE and prog_ctr SHALL hold.
REQ-008 Otherwise in RUN, the next PC SHALL follow this priority:
- abs_en & cond -> LUT[lut_idx];
- else rel_en & cond -> prog_ctr + sign-extended rel_off;
- else prog_ctr + 1.
REQ-009 If abs_en and rel_en are both set, the absolute branch SHALL win; a branch whose cond=0 SHALL fall through to prog_ctr + 1.
REQ-010 All PC arithmetic SHALL be modulo 2^D; wrap-around in either direction is legal and is not flagged.
REQ-011 cycle_cnt SHALL increment every cycle spent in RUN, stalled cycles included, and SHALL saturate at 2^CW-1.
REQ-012 cycle_cnt SHALL hold its value in DONE and in IDLE.
REQ-013 done SHALL be 1 exactly while the state is DONE; running SHALL be 1 exactly while the state is RUN.
REQ-014 In DONE, the FSM SHALL stay while req=1 and SHALL return to IDLE on the edge after req=0; prog_ctr SHALL hold throughout DONE.
REQ-015 req deasserted during RUN SHALL NOT abort the run.
REQ-016 A LUT write SHALL take effect on the next edge and SHALL be accepted in any state.
REQ-017 A same-cycle LUT write and branch read to the same index SHALL return the old entry.
REQ-018 In IDLE, halt, abs_en, rel_en and stall SHALL be ignored.

Reset
REQ-019 Reset SHALL have priority over every other input.
REQ-020 Reset SHALL set: state=IDLE, prog_ctr=0, cycle_cnt=0, done=0, running=0, and every LUT entry=0.
REQ-021 Reset asserted mid-RUN SHALL abandon the run; the FSM SHALL NOT pass through DONE.

Structure
REQ-022 The FSM state enum and the default values of D, LW and END_ADDR SHALL reside in a shared package, prog_pkg.
REQ-023 The programmable LUT SHALL be one sub-module, jump_lut, with a synchronous write port and a combinational read port.
REQ-024 All outputs SHALL be driven directly from registers.

Verification
REQ-025 Basic run:
- stimulus: reset, then req=1 for 1 cycle, no branches, END_ADDR=128;
- response: prog_ctr counts 0..128, done rises with prog_ctr=128, cycle_cnt=129.
REQ-026 Absolute branch:
- stimulus: write LUT[3]=40, then at prog_ctr=5 drive abs_en=1, cond=1, lut_idx=3;
- response: next prog_ctr=40.
- stimulus: same branch with cond=0;
- response: next prog_ctr=6.
REQ-027 Relative branch and wrap:
- stimulus: at prog_ctr=2 drive rel_en=1, cond=1, rel_off=-4 (D=12);
- response: next prog_ctr=4094.
- stimulus: abs_en and rel_en both set;
- response: the LUT target is taken.
REQ-028 Stall and halt:
- stimulus: stall=1 for 3 cycles at prog_ctr=10;
- response: prog_ctr holds at 10 and cycle_cnt advances by 3.
- stimulus: halt=1 together with stall=1;
- response: ignored.
- stimulus: halt=1 with stall=0;
- response: DONE on the next edge with prog_ctr=10.
REQ-029 Handshake and reset:
- stimulus: req held high through DONE;
- response: done stays 1.
- stimulus: req drops;
- response: IDLE one edge later, done=0.
- stimulus: reset at prog_ctr=50 mid-RUN;
- response: IDLE with prog_ctr=0, done never asserted, LUT entries read 0.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared types and default sizing for the program sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int D_DEF        = 12;
    localparam int LW_DEF       = 5;
    localparam int END_ADDR_DEF = 128;
    localparam int CW_DEF       = 16;

endpackage

// File: rtl/jump_lut.sv
// Programmable jump-target table: synchronous write, combinational read.
// Latency: write visible on the edge after lut_we; read is same-cycle.
// Backpressure: none, a write is accepted every cycle.
module jump_lut
    import prog_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [LW-1:0] waddr,
    input  logic [D-1:0]  wdata,
    input  logic [LW-1:0] raddr,
    output logic [D-1:0]  rdata
);

    logic [D-1:0] mem [2**LW];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**LW; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-write contents when raddr == waddr in the same cycle.
    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Program-counter sequencer with IDLE/RUN/DONE control, LUT and relative branches.
// Latency: one edge from req to RUN, one edge per PC step, one edge from halt/end to DONE.
// Backpressure: stall freezes PC and branch evaluation while cycle_cnt keeps counting.
module prog_sequencer
    import prog_pkg::*;
#(
    parameter int D        = D_DEF,
    parameter int LW       = LW_DEF,
    parameter int END_ADDR = END_ADDR_DEF,
    parameter int CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic          halt,
    input  logic          abs_en,
    input  logic          rel_en,
    input  logic          cond,
    input  logic [LW-1:0] lut_idx,
    input  logic [7:0]    rel_off,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] cycle_cnt
);

    localparam logic [D-1:0] END_PC = END_ADDR[D-1:0];

    state_t        state;
    state_t        state_nxt;
    logic [D-1:0]  pc_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [D-1:0]  lut_rdata;
    logic [D-1:0]  rel_ext;

    jump_lut #(
        .D  (D),
        .LW (LW)
    ) u_jump_lut (
        .clk   (clk),
        .reset (reset),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (lut_idx),
        .rdata (lut_rdata)
    );

    assign rel_ext = D'(signed'(rel_off));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            prog_ctr  <= '0;
            cycle_cnt <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            prog_ctr  <= pc_nxt;
            cycle_cnt <= cnt_nxt;
            running   <= (state_nxt == ST_RUN);
            done      <= (state_nxt == ST_DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ctr;
        cnt_nxt   = cycle_cnt;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = '0;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                // Stalled cycles still count as time spent running.
                if (cycle_cnt != '1) begin
                    cnt_nxt = cycle_cnt + CW'(1);
                end
                if (!stall) begin
                    if (halt || (prog_ctr == END_PC)) begin
                        state_nxt = ST_DONE;
                    end else if (abs_en && cond) begin
                        pc_nxt = lut_rdata;
                    end else if (rel_en && cond) begin
                        pc_nxt = prog_ctr + rel_ext;
                    end else begin
                        pc_nxt = prog_ctr + D'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
